// File: rtl/regfile.sv
// regfile: 32 x WIDTH architectural register file.
//   Write port : clock-edge write (ctrl_writeEnable / ctrl_writeRegister / data_writeReg)
//   Read ports : two combinational 32:1 word muxes (A, B) with write-through bypass
//   Dump port  : streams r0..r31 under dump_valid/dump_ready; dump_busy while scanning,
//                dump_done pulses for one cycle after r31 transfers.
// Reset is synchronous, active-high, and clears storage and the dump FSM.
module regfile #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeRegister,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [4:0]       dump_index,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [4:0] LAST = 5'd31;

  logic [WIDTH-1:0] regs_q [32];
  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wr_ok;
  logic             xfer;

  // r0 is hardwired when ZERO_REG is set, so writes to it are dropped.
  assign wr_ok = ctrl_writeEnable && !(ZERO_REG && (ctrl_writeRegister == 5'd0));

  // Storage
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[ctrl_writeRegister] <= data_writeReg;
    end
  end

  // Read ports: hardwired zero first, then bypass, then storage.
  always_comb begin
    data_readRegA = regs_q[ctrl_readRegA];
    if (ZERO_REG && (ctrl_readRegA == 5'd0))                  data_readRegA = '0;
    else if (wr_ok && (ctrl_writeRegister == ctrl_readRegA)) data_readRegA = data_writeReg;
  end

  always_comb begin
    data_readRegB = regs_q[ctrl_readRegB];
    if (ZERO_REG && (ctrl_readRegB == 5'd0))                  data_readRegB = '0;
    else if (wr_ok && (ctrl_writeRegister == ctrl_readRegB)) data_readRegB = data_writeReg;
  end

  // Dump FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign xfer = (state_q == SCAN) && dump_ready;

  // Dump FSM: next state. dump_start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dump_start) state_d = SCAN;
      end
      SCAN: begin
        if (xfer) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Dump FSM: outputs. dump_data reads storage directly (no bypass), so a
  // write to the word being transferred lands after the old value goes out.
  always_comb begin
    dump_valid = (state_q == SCAN);
    dump_busy  = (state_q == SCAN);
    dump_index = cnt_q;
    dump_data  = regs_q[cnt_q];
    dump_done  = done_q;
  end

endmodule
